// File: rtl/prbs4_checker_if.sv
// Signal bundle between a PRBS4 word source and prbs4_checker.
// The source drives the master side; the checker sits on the slave side.
interface prbs4_checker_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             data_valid;
  logic [3:0]       data_in;
  logic             clear_cnt;
  logic             locked;
  logic             err_pulse;
  logic             sync_loss;
  logic [CNT_W-1:0] err_count;
  logic             stuck;

  modport master (
    output data_valid, data_in, clear_cnt,
    input  locked, err_pulse, sync_loss, err_count, stuck
  );

  modport slave (
    input  data_valid, data_in, clear_cnt,
    output locked, err_pulse, sync_loss, err_count, stuck
  );
endinterface

// File: rtl/prbs4_checker.sv
// PRBS4 (x^4+x^3+1, period 15) receive checker with HUNT/VERIFY/LOCKED sync FSM.
// Define PRBS4_CHK_STUCK_DET_EN to build the all-zero lockup detector behind `stuck`.
module prbs4_checker #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3,
  parameter int unsigned CNT_W      = 16
) (
  input logic                 clk,
  input logic                 rst,
  prbs4_checker_if.slave      bus
);

  localparam logic [3:0] LockThr = 4'(LOCK_COUNT);
  localparam logic [3:0] LossThr = 4'(LOSS_COUNT);

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  state_e           state;
  logic [3:0]       expected;
  logic [3:0]       run;
  logic [3:0]       bad;
  logic             locked;
  logic             err_pulse;
  logic             sync_loss;
  logic [CNT_W-1:0] err_count;

  function automatic logic [3:0] nxt(input logic [3:0] w);
    return {w[2:0], w[3] ^ w[2]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StHunt;
      expected  <= 4'hF;
      run       <= 4'd0;
      bad       <= 4'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      sync_loss <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      sync_loss <= 1'b0;
      if (bus.data_valid) begin
        unique case (state)
          StHunt: begin
            // An all-zero word cannot seed the LFSR, so keep hunting.
            if (bus.data_in != 4'd0) begin
              expected <= nxt(bus.data_in);
              run      <= 4'd1;
              state    <= StVerify;
            end
          end
          StVerify: begin
            if (bus.data_in == expected) begin
              expected <= nxt(bus.data_in);
              run      <= run + 4'd1;
              if (run + 4'd1 == LockThr) begin
                state  <= StLocked;
                locked <= 1'b1;
                bad    <= 4'd0;
              end
            end else begin
              state <= StHunt;
              run   <= 4'd0;
            end
          end
          StLocked: begin
            // Reference free-runs so one corrupted word does not derail it.
            expected <= nxt(expected);
            if (bus.data_in == expected) begin
              bad <= 4'd0;
            end else begin
              err_pulse <= 1'b1;
              if (err_count != '1) err_count <= err_count + CNT_W'(1);
              if (bad + 4'd1 == LossThr) begin
                state     <= StHunt;
                locked    <= 1'b0;
                sync_loss <= 1'b1;
                bad       <= 4'd0;
                run       <= 4'd0;
              end else begin
                bad <= bad + 4'd1;
              end
            end
          end
          default: state <= StHunt;
        endcase
      end
      if (bus.clear_cnt) err_count <= '0;
    end
  end

  assign bus.locked    = locked;
  assign bus.err_pulse = err_pulse;
  assign bus.sync_loss = sync_loss;
  assign bus.err_count = err_count;

`ifdef PRBS4_CHK_STUCK_DET_EN
  logic [1:0] zero_run;
  logic       stuck;

  // Independent of sync state: flags a source stuck in the LFSR lockup word.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_run <= 2'd0;
      stuck    <= 1'b0;
    end else if (bus.data_valid) begin
      if (bus.data_in == 4'd0) begin
        if (zero_run == 2'd3) stuck <= 1'b1;
        else                  zero_run <= zero_run + 2'd1;
      end else begin
        zero_run <= 2'd0;
        stuck    <= 1'b0;
      end
    end
  end

  assign bus.stuck = stuck;
`else
  assign bus.stuck = 1'b0;
`endif

endmodule

// File: tb/tb_prbs4_checker.sv
// Directed self-checking bench for prbs4_checker with default parameters.
module tb_prbs4_checker;

`ifdef PRBS4_CHK_STUCK_DET_EN
  localparam logic StuckEn = 1'b1;
`else
  localparam logic StuckEn = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  prbs4_checker_if #(.CNT_W(16)) bus_if ();

  prbs4_checker #(
    .LOCK_COUNT(4),
    .LOSS_COUNT(3),
    .CNT_W     (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one clock; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic [3:0] d, input logic clr);
    bus_if.data_valid = v;
    bus_if.data_in    = d;
    bus_if.clear_cnt  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d);
    step(1'b1, d, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus_if.data_valid = 1'b0;
    bus_if.data_in    = 4'd0;
    bus_if.clear_cnt  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_locked", {31'd0, bus_if.locked}, 32'd0);
    check("rst_err_pulse", {31'd0, bus_if.err_pulse}, 32'd0);
    check("rst_sync_loss", {31'd0, bus_if.sync_loss}, 32'd0);
    check("rst_err_count", {16'd0, bus_if.err_count}, 32'd0);
    check("rst_stuck", {31'd0, bus_if.stuck}, 32'd0);

    // Acquire: F,E,C,8 locks on the fourth word.
    send(4'hF); send(4'hE); send(4'hC);
    check("acq_not_yet", {31'd0, bus_if.locked}, 32'd0);
    send(4'h8);
    check("acq_locked", {31'd0, bus_if.locked}, 32'd1);
    check("acq_err_count", {16'd0, bus_if.err_count}, 32'd0);

    // Idle cycle changes nothing.
    step(1'b0, 4'h3, 1'b0);
    check("idle_locked", {31'd0, bus_if.locked}, 32'd1);
    check("idle_err_pulse", {31'd0, bus_if.err_pulse}, 32'd0);

    // Single error: 2 where 1 expected, reference keeps running (2, 4 next).
    send(4'h2);
    check("err1_pulse", {31'd0, bus_if.err_pulse}, 32'd1);
    check("err1_count", {16'd0, bus_if.err_count}, 32'd1);
    check("err1_sync_loss", {31'd0, bus_if.sync_loss}, 32'd0);
    send(4'h2);
    check("err1_recover_pulse", {31'd0, bus_if.err_pulse}, 32'd0);
    send(4'h4);
    check("err1_locked", {31'd0, bus_if.locked}, 32'd1);
    check("err1_count_hold", {16'd0, bus_if.err_count}, 32'd1);

    // Clear on an idle cycle.
    step(1'b0, 4'h0, 1'b1);
    check("clr_idle", {16'd0, bus_if.err_count}, 32'd0);

    // Loss of sync: three wrong words (expected 9,3,6).
    send(4'h0);
    check("loss1_pulse", {31'd0, bus_if.err_pulse}, 32'd1);
    check("loss1_locked", {31'd0, bus_if.locked}, 32'd1);
    send(4'h0);
    check("loss2_sync_loss", {31'd0, bus_if.sync_loss}, 32'd0);
    send(4'h0);
    check("loss3_pulse", {31'd0, bus_if.err_pulse}, 32'd1);
    check("loss3_sync_loss", {31'd0, bus_if.sync_loss}, 32'd1);
    check("loss3_locked", {31'd0, bus_if.locked}, 32'd0);
    check("loss3_count", {16'd0, bus_if.err_count}, 32'd3);
    step(1'b0, 4'h0, 1'b0);
    check("loss_pulse_clears", {31'd0, bus_if.sync_loss}, 32'd0);

    // VERIFY mismatch falls back to HUNT without counting.
    send(4'hF); send(4'hE); send(4'h5);
    check("vfy_fail_count", {16'd0, bus_if.err_count}, 32'd3);
    check("vfy_fail_pulse", {31'd0, bus_if.err_pulse}, 32'd0);
    send(4'hF); send(4'hE); send(4'hC); send(4'h8);
    check("relock", {31'd0, bus_if.locked}, 32'd1);
    check("relock_count_kept", {16'd0, bus_if.err_count}, 32'd3);

    // Build err_count = 2 with bad reset by a match in between, then clear vs mismatch.
    step(1'b0, 4'h0, 1'b1);
    send(4'h0); // expected 1
    send(4'h2); // match
    send(4'h0); // expected 4
    check("pre_clr_count", {16'd0, bus_if.err_count}, 32'd2);
    step(1'b1, 4'h0, 1'b1); // expected 9, mismatch with clear
    check("clr_win_count", {16'd0, bus_if.err_count}, 32'd0);
    check("clr_win_pulse", {31'd0, bus_if.err_pulse}, 32'd1);
    check("clr_win_locked", {31'd0, bus_if.locked}, 32'd1);
    send(4'h3); // match resets bad
    send(4'h0); // expected 6
    check("post_clr_locked", {31'd0, bus_if.locked}, 32'd1);
    check("post_clr_count", {16'd0, bus_if.err_count}, 32'd1);

    // Reset wins over valid data and clear.
    rst = 1'b1;
    step(1'b1, 4'hD, 1'b1);
    rst = 1'b0;
    check("midrst_locked", {31'd0, bus_if.locked}, 32'd0);
    check("midrst_count", {16'd0, bus_if.err_count}, 32'd0);
    check("midrst_pulse", {31'd0, bus_if.err_pulse}, 32'd0);

    // Stuck detector: idle cycles do not break or extend the zero run.
    send(4'h0); send(4'h0);
    step(1'b0, 4'h0, 1'b0);
    send(4'h0);
    check("stuck_three", {31'd0, bus_if.stuck}, 32'd0);
    send(4'h0);
    check("stuck_four", {31'd0, bus_if.stuck}, {31'd0, StuckEn});
    send(4'h0);
    check("stuck_hold", {31'd0, bus_if.stuck}, {31'd0, StuckEn});
    send(4'hF);
    check("stuck_release", {31'd0, bus_if.stuck}, 32'd0);
    check("stuck_hunt_locked", {31'd0, bus_if.locked}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
